// File: rtl/grayscale_pixel_pipe.sv
// grayscale_pixel_pipe: RGBA-to-luma compute stage, 3-cycle fixed latency, with job line tracking.
// Define GRAYSCALE_PIPE_CHECKSUM_EN to enable the running XOR checksum of emitted lines.
`default_nettype none

module grayscale_pixel_pipe #(
  parameter int unsigned NUM_PIX          = 16,
  parameter int unsigned COEF_R           = 77,
  parameter int unsigned COEF_G           = 150,
  parameter int unsigned COEF_B           = 29,
  parameter int unsigned CNT_W            = 32,
  parameter logic [31:0] HC_CONTROL_START = 32'h0000_0001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            hc_control,
  input  logic [CNT_W-1:0]       num_lines,
  input  logic [32*NUM_PIX-1:0]  data_in,
  input  logic                   valid_in,
  output logic [32*NUM_PIX-1:0]  data_out,
  output logic                   valid_out,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       lines_out,
  output logic [15:0]            drop_cnt,
  output logic [31:0]            checksum
);

  localparam int unsigned      LINE_W  = 32 * NUM_PIX;
  localparam logic [7:0]       CR      = 8'(COEF_R);
  localparam logic [7:0]       CG      = 8'(COEF_G);
  localparam logic [7:0]       CB      = 8'(COEF_B);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     busy_q, done_q;
  logic [CNT_W-1:0]         target_q, lines_q;
  logic [15:0]              drop_q;
  logic                     v1_q, v2_q, vout_q;
  logic [NUM_PIX-1:0][15:0] pr_q, pg_q, pb_q, sum_q;
  logic [NUM_PIX-1:0][7:0]  a1_q, a2_q;
  logic [LINE_W-1:0]        dout_q;

  logic [NUM_PIX-1:0][15:0] pr_d, pg_d, pb_d, sum_d;
  logic [NUM_PIX-1:0][7:0]  a1_d;
  logic [LINE_W-1:0]        dout_d;

  logic start, abort, accept, drop_inc;

  assign start    = (hc_control == HC_CONTROL_START);
  assign abort    = (state_q == ST_RUN) && !start;
  assign accept   = (state_q == ST_RUN) && start && valid_in;
  assign drop_inc = valid_in && (state_q != ST_RUN) && (drop_q != 16'hFFFF);

  // Coefficients sum to 256, so the 16-bit sum cannot overflow and Y is its upper byte.
  always_comb begin
    pr_d   = '0;
    pg_d   = '0;
    pb_d   = '0;
    a1_d   = '0;
    sum_d  = '0;
    dout_d = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      pr_d[i]  = 16'(data_in[32*i +: 8])    * 16'(CR);
      pg_d[i]  = 16'(data_in[32*i+8 +: 8])  * 16'(CG);
      pb_d[i]  = 16'(data_in[32*i+16 +: 8]) * 16'(CB);
      a1_d[i]  = data_in[32*i+24 +: 8];
      sum_d[i] = pr_q[i] + pg_q[i] + pb_q[i];
      dout_d[32*i +: 32] = {a2_q[i], 8'(sum_q[i] >> 8), 8'(sum_q[i] >> 8), 8'(sum_q[i] >> 8)};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      vout_q <= 1'b0;
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      a1_q   <= '0;
      sum_q  <= '0;
      a2_q   <= '0;
      dout_q <= '0;
    end else begin
      v1_q   <= accept;
      v2_q   <= v1_q && !abort;
      vout_q <= v2_q && !abort;
      if (accept) begin
        pr_q <= pr_d;
        pg_q <= pg_d;
        pb_q <= pb_d;
        a1_q <= a1_d;
      end
      if (v1_q) begin
        sum_q <= sum_d;
        a2_q  <= a1_q;
      end
      if (v2_q && !abort) begin
        dout_q <= dout_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      target_q <= '0;
      lines_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (drop_inc) begin
        drop_q <= drop_q + 16'd1;
      end
      if (vout_q) begin
        lines_q <= lines_q + CNT_ONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            target_q <= num_lines;
            lines_q  <= '0;
            if (num_lines == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!start) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (vout_q && ((lines_q + CNT_ONE) == target_q)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!start) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lines_out = lines_q;
  assign drop_cnt  = drop_q;

`ifdef GRAYSCALE_PIPE_CHECKSUM_EN
  logic [31:0] cs_q;
  logic [31:0] line_xor;

  always_comb begin
    line_xor = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      line_xor = line_xor ^ dout_q[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      cs_q <= '0;
    end else if (vout_q) begin
      cs_q <= cs_q ^ line_xor;
    end
  end

  assign checksum = cs_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_grayscale_pixel_pipe.sv
// Testbench for grayscale_pixel_pipe: constant vectors, hand-written job sequences and
// randomized jobs checked every cycle against a queue-based reference model.
`default_nettype none

module tb_grayscale_pixel_pipe;

  localparam int          NUM_PIX = 16;
  localparam int          CNT_W   = 32;
  localparam int          LW      = 32 * NUM_PIX;
  localparam logic [31:0] START   = 32'h0000_0001;
`ifdef GRAYSCALE_PIPE_CHECKSUM_EN
  localparam bit          CS_EN   = 1'b1;
`else
  localparam bit          CS_EN   = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic [31:0]      hc_control = '0;
  logic [CNT_W-1:0] num_lines  = '0;
  logic [LW-1:0]    data_in    = '0;
  logic             valid_in   = 1'b0;
  logic [LW-1:0]    data_out;
  logic             valid_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] lines_out;
  logic [15:0]      drop_cnt;
  logic [31:0]      checksum;

  int checks = 0;
  int errors = 0;

  grayscale_pixel_pipe #(
    .NUM_PIX(NUM_PIX), .COEF_R(77), .COEF_G(150), .COEF_B(29),
    .CNT_W(CNT_W), .HC_CONTROL_START(START)
  ) dut (
    .clk(clk), .reset(reset), .hc_control(hc_control), .num_lines(num_lines),
    .data_in(data_in), .valid_in(valid_in), .data_out(data_out), .valid_out(valid_out),
    .busy(busy), .done(done), .lines_out(lines_out), .drop_cnt(drop_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: accepted lines wait in a queue with the edge at which they must appear.
  typedef struct {
    logic [LW-1:0] line;
    int            due;
  } exp_t;

  typedef struct {
    logic [31:0] pix;
    logic [31:0] exp;
  } vec_t;

  exp_t             q[$];
  int               m_st;
  int               m_e;
  logic [CNT_W-1:0] m_target;
  logic [CNT_W-1:0] m_lines;
  logic [15:0]      m_drop;
  logic [31:0]      m_cs;
  logic             m_vout;
  logic [LW-1:0]    m_dout;

  function automatic logic [LW-1:0] conv(input logic [LW-1:0] l);
    logic [LW-1:0] o;
    int r, g, b, y;
    o = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      r = {24'd0, l[32*i +: 8]};
      g = {24'd0, l[32*i+8 +: 8]};
      b = {24'd0, l[32*i+16 +: 8]};
      y = (77 * r + 150 * g + 29 * b) / 256;
      o[32*i +: 32] = {l[32*i+24 +: 8], 8'(y), 8'(y), 8'(y)};
    end
    return o;
  endfunction

  function automatic logic [31:0] lxor(input logic [LW-1:0] l);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < NUM_PIX; i++) x = x ^ l[32*i +: 32];
    return x;
  endfunction

  function automatic logic [LW-1:0] rline();
    logic [LW-1:0] o;
    o = '0;
    for (int i = 0; i < NUM_PIX; i++) o[32*i +: 32] = $urandom;
    return o;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mreset();
    m_st     = M_IDLE;
    m_e      = 0;
    m_target = '0;
    m_lines  = '0;
    m_drop   = '0;
    m_cs     = '0;
    m_vout   = 1'b0;
    m_dout   = '0;
    q.delete();
  endtask

  // Apply one cycle of inputs, advance the model over the same edge, compare all outputs.
  task automatic cycle(input logic [31:0] hc, input logic [CNT_W-1:0] nl,
                       input logic [LW-1:0] din, input logic vin);
    bit   run_req;
    bit   prev;
    exp_t e;
    hc_control = hc;
    num_lines  = nl;
    data_in    = din;
    valid_in   = vin;
    tick();
    m_e++;
    run_req = (hc == START);
    prev    = m_vout;
    if (prev) begin
      m_lines = m_lines + 1;
      m_cs    = m_cs ^ lxor(m_dout);
    end
    case (m_st)
      M_IDLE: begin
        if (vin && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        if (run_req) begin
          m_target = nl;
          m_lines  = '0;
          m_cs     = '0;
          m_st     = (nl == 0) ? M_DONE : M_RUN;
        end
      end
      M_RUN: begin
        if (!run_req) begin
          m_st = M_IDLE;
          q.delete();
        end else begin
          if (vin) begin
            e.line = conv(din);
            e.due  = m_e + 2;
            q.push_back(e);
          end
          if (prev && m_lines == m_target) m_st = M_DONE;
        end
      end
      default: begin
        if (vin && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        if (!run_req) m_st = M_IDLE;
      end
    endcase
    m_vout = 1'b0;
    if (q.size() > 0 && q[0].due == m_e) begin
      m_vout = 1'b1;
      m_dout = q[0].line;
      void'(q.pop_front());
    end
    chk("valid_out", valid_out, m_vout);
    chk("data_out", data_out, m_dout);
    chk("busy", busy, m_st == M_RUN);
    chk("done", done, m_st == M_DONE);
    chk("lines_out", lines_out, m_lines);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("checksum", checksum, CS_EN ? m_cs : 32'd0);
  endtask

  initial begin
    vec_t             vt[5];
    int               nv;
    int               sent;
    int               tmp;
    bit               aborted;
    logic             vin;
    logic [15:0]      d0;
    logic [CNT_W-1:0] nl;
    logic [LW-1:0]    lp;

    vt[0] = '{32'h000000FF, 32'h004C4C4C};
    vt[1] = '{32'h0000FF00, 32'h00959595};
    vt[2] = '{32'h00FF0000, 32'h001C1C1C};
    vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[4] = '{32'h7F000000, 32'h7F000000};

    mreset();
    #3 reset = 1'b0;
    tick();
    tick();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lines_out", lines_out, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b1;

    // valid_in while idle is only counted
    for (int k = 0; k < 3; k++) cycle('0, '0, rline(), 1'b1);
    chk("idle_drop3", drop_cnt, 3);

    // single-colour lines, one-line jobs
    for (int i = 0; i < 5; i++) begin
      cycle(START, 1, '0, 1'b0);
      cycle(START, 1, {16{vt[i].pix}}, 1'b1);
      cycle(START, 1, '0, 1'b0);
      cycle(START, 1, '0, 1'b0);
      chk("tbl_valid", valid_out, 1);
      chk("tbl_data", data_out, {16{vt[i].exp}});
      cycle(START, 1, '0, 1'b0);
      chk("tbl_done", done, 1);
      cycle('0, '0, '0, 1'b0);
    end

    // four back-to-back lines
    nv = 0;
    cycle(START, 4, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(START, 4, rline(), 1'b1);
      if (valid_out) nv++;
    end
    for (int k = 0; k < 2; k++) begin
      cycle(START, 4, '0, 1'b0);
      if (valid_out) nv++;
    end
    chk("flow_vout_count", nv, 4);
    chk("flow_done_early", done, 0);
    cycle(START, 4, '0, 1'b0);
    chk("flow_done", done, 1);
    chk("flow_lines", lines_out, 4);
    chk("flow_vout_end", valid_out, 0);
    cycle('0, '0, '0, 1'b0);
    chk("flow_idle_done", done, 0);

    // abort with two lines in flight and a coincident valid_in
    cycle(START, 8, '0, 1'b0);
    cycle(START, 8, rline(), 1'b1);
    cycle(START, 8, rline(), 1'b1);
    d0 = drop_cnt;
    nv = 0;
    cycle('0, 8, rline(), 1'b1);
    if (valid_out) nv++;
    for (int k = 0; k < 5; k++) begin
      cycle('0, '0, '0, 1'b0);
      if (valid_out) nv++;
    end
    chk("abort_no_vout", nv, 0);
    chk("abort_lines", lines_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_drop", drop_cnt, d0);

    // checksum: identical-word lines cancel out
    cycle(START, 2, '0, 1'b0);
    cycle(START, 2, {16{32'h000000FF}}, 1'b1);
    cycle(START, 2, {16{32'hFFFFFFFF}}, 1'b1);
    for (int k = 0; k < 10 && !done; k++) cycle(START, 2, '0, 1'b0);
    chk("cks_done_reached", done, 1);
    chk("cks_two_lines", checksum, 0);
    cycle('0, '0, '0, 1'b0);
    lp = '0;
    lp[31:0] = 32'hFFFFFFFF;
    cycle(START, 1, '0, 1'b0);
    cycle(START, 1, lp, 1'b1);
    for (int k = 0; k < 10 && !done; k++) cycle(START, 1, '0, 1'b0);
    chk("cks_one_done", done, 1);
    chk("cks_one_pixel", checksum, CS_EN ? 32'hFFFFFFFF : 32'h0);
    cycle('0, '0, '0, 1'b0);

    // randomized jobs with gaps, occasional aborts and zero-length jobs
    for (int j = 0; j < 16; j++) begin
      nl = $urandom_range(0, 6);
      cycle(START, nl, rline(), 1'($urandom_range(0, 1)));
      sent    = 0;
      aborted = 1'b0;
      for (int k = 0; k < 40 && !done && !aborted; k++) begin
        if ((j % 5) == 4 && k == 2) begin
          cycle('0, nl, rline(), 1'($urandom_range(0, 1)));
          aborted = 1'b1;
        end else begin
          vin = (sent < nl) && ($urandom_range(0, 3) != 0);
          cycle(START, nl, rline(), vin);
          if (vin) sent++;
        end
      end
      if (!aborted) chk("rnd_done", done, 1);
      cycle('0, '0, '0, 1'b0);
    end

    // drop counter saturation
    hc_control = '0;
    valid_in   = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    valid_in = 1'b0;
    tmp = int'(m_drop) + 70000;
    m_drop = (tmp > 65535) ? 16'hFFFF : 16'(tmp);
    chk("drop_sat", drop_cnt, 16'hFFFF);
    cycle('0, '0, '0, 1'b0);
    cycle('0, '0, rline(), 1'b1);

    // asynchronous reset with lines in flight
    cycle(START, 8, '0, 1'b0);
    cycle(START, 8, rline(), 1'b1);
    cycle(START, 8, rline(), 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid_out", valid_out, 0);
    chk("arst_data_out", data_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_lines_out", lines_out, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    chk("arst_checksum", checksum, 0);
    tick();
    tick();
    hc_control = '0;
    valid_in   = 1'b0;
    reset      = 1'b1;
    mreset();
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      cycle('0, '0, '0, 1'b0);
      if (valid_out) nv++;
    end
    chk("arst_no_vout", nv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
